// File: rtl/packetmem_xbar.sv
// Packet-buffer crossbar: rotates N_BUF buffers between snooper, CPU and forwarder
// through free / cpu-ready / fwd-ready index FIFOs and routes each agent to its buffer.
module packetmem_xbar #(
  parameter int unsigned N_BUF      = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_OUT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         sn_addr,
  input  logic [DATA_WIDTH-1:0]         sn_wr_data,
  input  logic                          sn_wr_en,
  input  logic                          sn_done,
  output logic                          sn_has_buf,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic                          cpu_rd_en,
  input  logic                          cpu_accept,
  input  logic                          cpu_reject,
  output logic [DATA_WIDTH-1:0]         cpu_rd_data,
  output logic [ADDR_WIDTH-1:0]         cpu_len,
  output logic                          cpu_has_buf,
  input  logic [ADDR_WIDTH-1:0]         fwd_addr,
  input  logic                          fwd_rd_en,
  input  logic                          fwd_done,
  output logic [DATA_WIDTH-1:0]         fwd_rd_data,
  output logic [ADDR_WIDTH-1:0]         fwd_len,
  output logic                          fwd_has_buf,
  output logic [N_BUF*ADDR_WIDTH-1:0]   buf_addr,
  output logic [N_BUF*DATA_WIDTH-1:0]   buf_wr_data,
  output logic [N_BUF-1:0]              buf_wr_en,
  output logic [N_BUF-1:0]              buf_rd_en,
  input  logic [N_BUF*DATA_WIDTH-1:0]   buf_rd_data,
  input  logic [N_BUF*ADDR_WIDTH-1:0]   buf_len
);

  localparam int unsigned IdxW     = $clog2(N_BUF);
  localparam int unsigned CntW     = $clog2(N_BUF + 1);
  localparam int unsigned NumFifo  = 3;
  localparam int unsigned FifoFree = 0;
  localparam int unsigned FifoCpu  = 1;
  localparam int unsigned FifoFwd  = 2;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  // Circular position base+off+extra modulo N_BUF; the sum never exceeds 2*N_BUF.
  function automatic idx_t wrap(input idx_t base, input cnt_t off, input logic extra);
    int unsigned s;
    s = 32'(base) + 32'(off) + 32'(extra);
    if (s >= N_BUF) s = s - N_BUF;
    if (s >= N_BUF) s = s - N_BUF;
    return idx_t'(s);
  endfunction

  // Index FIFO state
  idx_t fifo_mem_q [NumFifo][N_BUF];
  idx_t fifo_mem_d [NumFifo][N_BUF];
  idx_t head_q [NumFifo];
  idx_t head_d [NumFifo];
  cnt_t cnt_q  [NumFifo];
  cnt_t cnt_d  [NumFifo];

  logic pop      [NumFifo];
  logic push0_v  [NumFifo];
  logic push1_v  [NumFifo];
  idx_t push0_idx[NumFifo];
  idx_t push1_idx[NumFifo];

  // Ownership state
  logic sn_has_q, sn_has_d, cpu_has_q, cpu_has_d, fwd_has_q, fwd_has_d;
  idx_t sn_idx_q, sn_idx_d, cpu_idx_q, cpu_idx_d, fwd_idx_q, fwd_idx_d;

  logic cpu_rej, fwd_rel;

  // Grant / release decisions; each agent either releases or is granted in one cycle.
  always_comb begin
    sn_has_d  = sn_has_q;
    sn_idx_d  = sn_idx_q;
    cpu_has_d = cpu_has_q;
    cpu_idx_d = cpu_idx_q;
    fwd_has_d = fwd_has_q;
    fwd_idx_d = fwd_idx_q;
    cpu_rej   = 1'b0;
    fwd_rel   = 1'b0;
    for (int f = 0; f < NumFifo; f++) begin
      pop[f]       = 1'b0;
      push0_v[f]   = 1'b0;
      push1_v[f]   = 1'b0;
      push0_idx[f] = '0;
      push1_idx[f] = '0;
    end

    if (sn_has_q) begin
      if (sn_done) begin
        sn_has_d           = 1'b0;
        push0_v[FifoCpu]   = 1'b1;
        push0_idx[FifoCpu] = sn_idx_q;
      end
    end else if (cnt_q[FifoFree] != '0) begin
      pop[FifoFree] = 1'b1;
      sn_has_d      = 1'b1;
      sn_idx_d      = fifo_mem_q[FifoFree][head_q[FifoFree]];
    end

    if (cpu_has_q) begin
      if (cpu_reject) begin
        cpu_has_d = 1'b0;
        cpu_rej   = 1'b1;
      end else if (cpu_accept) begin
        cpu_has_d          = 1'b0;
        push0_v[FifoFwd]   = 1'b1;
        push0_idx[FifoFwd] = cpu_idx_q;
      end
    end else if (cnt_q[FifoCpu] != '0) begin
      pop[FifoCpu] = 1'b1;
      cpu_has_d    = 1'b1;
      cpu_idx_d    = fifo_mem_q[FifoCpu][head_q[FifoCpu]];
    end

    if (fwd_has_q) begin
      if (fwd_done) begin
        fwd_has_d = 1'b0;
        fwd_rel   = 1'b1;
      end
    end else if (cnt_q[FifoFwd] != '0) begin
      pop[FifoFwd] = 1'b1;
      fwd_has_d    = 1'b1;
      fwd_idx_d    = fifo_mem_q[FifoFwd][head_q[FifoFwd]];
    end

    // Forwarder's buffer is enqueued ahead of the CPU's when both free at once.
    if (fwd_rel) begin
      push0_v[FifoFree]   = 1'b1;
      push0_idx[FifoFree] = fwd_idx_q;
      if (cpu_rej) begin
        push1_v[FifoFree]   = 1'b1;
        push1_idx[FifoFree] = cpu_idx_q;
      end
    end else if (cpu_rej) begin
      push0_v[FifoFree]   = 1'b1;
      push0_idx[FifoFree] = cpu_idx_q;
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    for (int f = 0; f < NumFifo; f++) begin
      if (push0_v[f]) begin
        fifo_mem_d[f][wrap(head_q[f], cnt_q[f], 1'b0)] = push0_idx[f];
      end
      if (push1_v[f]) begin
        fifo_mem_d[f][wrap(head_q[f], cnt_q[f], 1'b1)] = push1_idx[f];
      end
      if (pop[f]) begin
        head_d[f] = wrap(head_q[f], '0, 1'b1);
      end
      cnt_d[f] = cnt_q[f] + cnt_t'(push0_v[f]) + cnt_t'(push1_v[f]) - cnt_t'(pop[f]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NumFifo; f++) begin
        head_q[f] <= '0;
        cnt_q[f]  <= '0;
        for (int i = 0; i < N_BUF; i++) begin
          fifo_mem_q[f][i] <= '0;
        end
      end
      for (int i = 0; i < N_BUF; i++) begin
        fifo_mem_q[FifoFree][i] <= idx_t'(i);
      end
      cnt_q[FifoFree] <= cnt_t'(N_BUF);
      sn_has_q        <= 1'b0;
      cpu_has_q       <= 1'b0;
      fwd_has_q       <= 1'b0;
      sn_idx_q        <= '0;
      cpu_idx_q       <= '0;
      fwd_idx_q       <= '0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      sn_has_q   <= sn_has_d;
      cpu_has_q  <= cpu_has_d;
      fwd_has_q  <= fwd_has_d;
      sn_idx_q   <= sn_idx_d;
      cpu_idx_q  <= cpu_idx_d;
      fwd_idx_q  <= fwd_idx_d;
    end
  end

  assign sn_has_buf  = sn_has_q;
  assign cpu_has_buf = cpu_has_q;
  assign fwd_has_buf = fwd_has_q;

  // Buffer-side request routing; owners hold distinct indices.
  logic [N_BUF*ADDR_WIDTH-1:0] buf_addr_d;
  logic [N_BUF*DATA_WIDTH-1:0] buf_wr_data_d;
  logic [N_BUF-1:0]            buf_wr_en_d;
  logic [N_BUF-1:0]            buf_rd_en_d;

  always_comb begin
    buf_addr_d    = '0;
    buf_wr_data_d = '0;
    buf_wr_en_d   = '0;
    buf_rd_en_d   = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (sn_has_q && sn_idx_q == idx_t'(i)) begin
        buf_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH]    = sn_addr;
        buf_wr_data_d[i*DATA_WIDTH +: DATA_WIDTH] = sn_wr_data;
        buf_wr_en_d[i]                            = sn_wr_en;
      end else if (cpu_has_q && cpu_idx_q == idx_t'(i)) begin
        buf_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = cpu_addr;
        buf_rd_en_d[i]                         = cpu_rd_en;
      end else if (fwd_has_q && fwd_idx_q == idx_t'(i)) begin
        buf_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = fwd_addr;
        buf_rd_en_d[i]                         = fwd_rd_en;
      end
    end
  end

  always_comb begin
    cpu_rd_data = '0;
    cpu_len     = '0;
    fwd_rd_data = '0;
    fwd_len     = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (cpu_has_q && cpu_idx_q == idx_t'(i)) begin
        cpu_rd_data = buf_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        cpu_len     = buf_len[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (fwd_has_q && fwd_idx_q == idx_t'(i)) begin
        fwd_rd_data = buf_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        fwd_len     = buf_len[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [N_BUF*ADDR_WIDTH-1:0] buf_addr_q;
    logic [N_BUF*DATA_WIDTH-1:0] buf_wr_data_q;
    logic [N_BUF-1:0]            buf_wr_en_q;
    logic [N_BUF-1:0]            buf_rd_en_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        buf_addr_q    <= '0;
        buf_wr_data_q <= '0;
        buf_wr_en_q   <= '0;
        buf_rd_en_q   <= '0;
      end else begin
        buf_addr_q    <= buf_addr_d;
        buf_wr_data_q <= buf_wr_data_d;
        buf_wr_en_q   <= buf_wr_en_d;
        buf_rd_en_q   <= buf_rd_en_d;
      end
    end

    assign buf_addr    = buf_addr_q;
    assign buf_wr_data = buf_wr_data_q;
    assign buf_wr_en   = buf_wr_en_q;
    assign buf_rd_en   = buf_rd_en_q;
  end else begin : g_comb_out
    assign buf_addr    = buf_addr_d;
    assign buf_wr_data = buf_wr_data_d;
    assign buf_wr_en   = buf_wr_en_d;
    assign buf_rd_en   = buf_rd_en_d;
  end

endmodule

// File: tb/tb_packetmem_xbar.sv
// Bench for packetmem_xbar: directed rotation scenarios plus random traffic against a
// queue-based ownership model; a second REG_OUT=1, N_BUF=3 instance checks output latency.
module tb_packetmem_xbar;

  localparam int NB  = 4;
  localparam int NB3 = 3;
  localparam int AW  = 10;
  localparam int DW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] sn_addr, cpu_addr, fwd_addr;
  logic [DW-1:0] sn_wr_data;
  logic          sn_wr_en, sn_done, cpu_rd_en, cpu_accept, cpu_reject, fwd_rd_en, fwd_done;
  logic          sn_has_buf, cpu_has_buf, fwd_has_buf;
  logic [DW-1:0] cpu_rd_data, fwd_rd_data;
  logic [AW-1:0] cpu_len, fwd_len;
  logic [NB*AW-1:0] buf_addr, buf_len;
  logic [NB*DW-1:0] buf_wr_data, buf_rd_data;
  logic [NB-1:0]    buf_wr_en, buf_rd_en;

  packetmem_xbar #(.N_BUF(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_OUT(0)) dut (
    .clk(clk), .rst(rst),
    .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en), .sn_done(sn_done),
    .sn_has_buf(sn_has_buf),
    .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_accept(cpu_accept),
    .cpu_reject(cpu_reject), .cpu_rd_data(cpu_rd_data), .cpu_len(cpu_len),
    .cpu_has_buf(cpu_has_buf),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_done(fwd_done),
    .fwd_rd_data(fwd_rd_data), .fwd_len(fwd_len), .fwd_has_buf(fwd_has_buf),
    .buf_addr(buf_addr), .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en),
    .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .buf_len(buf_len)
  );

  // Second instance: registered outputs, legacy three buffers.
  logic            g_rst, g_sn_wr_en, g_sn_has, g_cpu_has, g_fwd_has;
  logic [AW-1:0]   g_sn_addr, g_cpu_len, g_fwd_len;
  logic [DW-1:0]   g_sn_wr_data, g_cpu_rd_data, g_fwd_rd_data;
  logic [NB3*AW-1:0] g_buf_addr;
  logic [NB3*DW-1:0] g_buf_wr_data;
  logic [NB3-1:0]    g_buf_wr_en, g_buf_rd_en;

  packetmem_xbar #(.N_BUF(NB3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_OUT(1)) dut3 (
    .clk(clk), .rst(g_rst),
    .sn_addr(g_sn_addr), .sn_wr_data(g_sn_wr_data), .sn_wr_en(g_sn_wr_en), .sn_done(1'b0),
    .sn_has_buf(g_sn_has),
    .cpu_addr('0), .cpu_rd_en(1'b0), .cpu_accept(1'b0), .cpu_reject(1'b0),
    .cpu_rd_data(g_cpu_rd_data), .cpu_len(g_cpu_len), .cpu_has_buf(g_cpu_has),
    .fwd_addr('0), .fwd_rd_en(1'b0), .fwd_done(1'b0),
    .fwd_rd_data(g_fwd_rd_data), .fwd_len(g_fwd_len), .fwd_has_buf(g_fwd_has),
    .buf_addr(g_buf_addr), .buf_wr_data(g_buf_wr_data), .buf_wr_en(g_buf_wr_en),
    .buf_rd_en(g_buf_rd_en), .buf_rd_data('0), .buf_len('0)
  );

  // Behavioural packet buffers (64 words each, async read).
  logic [DW-1:0] mem [NB][64];
  logic          mem_clr;

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      for (int a = 0; a < 64; a++) begin
        if (mem_clr) mem[i][a] <= '0;
      end
      if (!mem_clr && buf_wr_en[i]) mem[i][buf_addr[i*AW +: 6]] <= buf_wr_data[i*DW +: DW];
    end
  end

  always_comb begin
    buf_rd_data = '0;
    for (int i = 0; i < NB; i++) buf_rd_data[i*DW +: DW] = mem[i][buf_addr[i*AW +: 6]];
  end

  int errors = 0;
  int checks = 0;

  // Reference model: buffer indices move between queues and agent slots.
  int m_free[$], m_cpuq[$], m_fwdq[$];
  bit m_sn_has, m_cpu_has, m_fwd_has;
  int m_sn_idx, m_cpu_idx, m_fwd_idx;

  function automatic void model_edge();
    bit sn_rel, cpu_rej, cpu_acc, fwd_rel;
    int sn_i, cpu_i, fwd_i;
    if (rst) begin
      m_free = {};
      m_cpuq = {};
      m_fwdq = {};
      for (int i = 0; i < NB; i++) m_free.push_back(i);
      m_sn_has  = 0;
      m_cpu_has = 0;
      m_fwd_has = 0;
      return;
    end
    sn_rel  = m_sn_has && sn_done;
    cpu_rej = m_cpu_has && cpu_reject;
    cpu_acc = m_cpu_has && cpu_accept && !cpu_reject;
    fwd_rel = m_fwd_has && fwd_done;
    sn_i  = m_sn_idx;
    cpu_i = m_cpu_idx;
    fwd_i = m_fwd_idx;
    if (sn_rel) m_sn_has = 0;
    else if (!m_sn_has && m_free.size() > 0) begin m_sn_idx = m_free.pop_front(); m_sn_has = 1; end
    if (cpu_rej || cpu_acc) m_cpu_has = 0;
    else if (!m_cpu_has && m_cpuq.size() > 0) begin
      m_cpu_idx = m_cpuq.pop_front();
      m_cpu_has = 1;
    end
    if (fwd_rel) m_fwd_has = 0;
    else if (!m_fwd_has && m_fwdq.size() > 0) begin
      m_fwd_idx = m_fwdq.pop_front();
      m_fwd_has = 1;
    end
    if (sn_rel)  m_cpuq.push_back(sn_i);
    if (cpu_acc) m_fwdq.push_back(cpu_i);
    if (fwd_rel) m_free.push_back(fwd_i);
    if (cpu_rej) m_free.push_back(cpu_i);
  endfunction

  function automatic logic [NB-1:0] exp_wr_en();
    logic [NB-1:0] e = '0;
    if (m_sn_has) e[m_sn_idx] = sn_wr_en;
    return e;
  endfunction

  function automatic logic [NB-1:0] exp_rd_en();
    logic [NB-1:0] e = '0;
    if (m_cpu_has) e[m_cpu_idx] = cpu_rd_en;
    if (m_fwd_has) e[m_fwd_idx] = fwd_rd_en;
    return e;
  endfunction

  function automatic logic [NB*AW-1:0] exp_addr();
    logic [NB*AW-1:0] e = '0;
    if (m_sn_has)  e[m_sn_idx*AW +: AW]  = sn_addr;
    if (m_cpu_has) e[m_cpu_idx*AW +: AW] = cpu_addr;
    if (m_fwd_has) e[m_fwd_idx*AW +: AW] = fwd_addr;
    return e;
  endfunction

  function automatic logic [NB*DW-1:0] exp_wdata();
    logic [NB*DW-1:0] e = '0;
    if (m_sn_has) e[m_sn_idx*DW +: DW] = sn_wr_data;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    sn_addr = '0; sn_wr_data = '0; sn_wr_en = 0; sn_done = 0;
    cpu_addr = '0; cpu_rd_en = 0; cpu_accept = 0; cpu_reject = 0;
    fwd_addr = '0; fwd_rd_en = 0; fwd_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; mem_clr = 1;
    tick(); tick();
    mem_clr = 0;
    checks++;
    if ({sn_has_buf, cpu_has_buf, fwd_has_buf, buf_wr_en, buf_rd_en} !== '0 || buf_addr !== '0)
      begin errors++; $display("FAIL reset_outputs has=%b%b%b wr_en=%b addr=%h want all zero",
        sn_has_buf, cpu_has_buf, fwd_has_buf, buf_wr_en, buf_addr); end
    rst = 0;
    tick();
    checks++;
    if ({sn_has_buf, cpu_has_buf, fwd_has_buf} !== 3'b100) begin
      errors++; $display("FAIL reset_grant has=%b%b%b want 100", sn_has_buf, cpu_has_buf,
        fwd_has_buf);
    end
    sn_wr_en = 1; #1;
    checks++;
    if (buf_wr_en !== 4'b0001) begin
      errors++; $display("FAIL reset_wr_follow got=%b want 0001", buf_wr_en);
    end
    sn_wr_en = 0; #1;
    checks++;
    if (buf_wr_en !== 4'b0000) begin
      errors++; $display("FAIL reset_wr_idle got=%b want 0000", buf_wr_en);
    end
  endtask

  task automatic test_handoff();
    sn_addr = 10'd5; sn_wr_data = 64'hA5; sn_wr_en = 1;
    tick();
    sn_wr_en = 0; sn_done = 1;
    tick();
    sn_done = 0;
    tick();
    checks++;
    if ({sn_has_buf, cpu_has_buf, fwd_has_buf} !== 3'b110) begin
      errors++; $display("FAIL handoff_has got=%b%b%b want 110", sn_has_buf, cpu_has_buf,
        fwd_has_buf);
    end
    cpu_addr = 10'd5; cpu_rd_en = 1; sn_wr_en = 1; #1;
    checks++;
    if (cpu_rd_data !== 64'hA5) begin
      errors++; $display("FAIL handoff_rd_data got=%h want a5", cpu_rd_data);
    end
    checks++;
    if (cpu_len !== buf_len[AW-1:0]) begin
      errors++; $display("FAIL handoff_len got=%0d want %0d", cpu_len, buf_len[AW-1:0]);
    end
    checks++;
    if (buf_rd_en !== 4'b0001 || buf_wr_en !== 4'b0010) begin
      errors++; $display("FAIL handoff_route rd_en=%b wr_en=%b want 0001 0010", buf_rd_en,
        buf_wr_en);
    end
    cpu_rd_en = 0; sn_wr_en = 0;
  endtask

  task automatic test_rotation();
    int order[3] = '{2, 3, 0};
    logic [NB-1:0] w;
    cpu_accept = 1; tick(); cpu_accept = 0;
    checks++;
    if ({cpu_has_buf, fwd_has_buf} !== 2'b00) begin
      errors++; $display("FAIL accept_gap cpu=%b fwd=%b want 0 0", cpu_has_buf, fwd_has_buf);
    end
    tick();
    fwd_rd_en = 1; #1;
    checks++;
    if (fwd_has_buf !== 1'b1 || buf_rd_en !== 4'b0001) begin
      errors++; $display("FAIL fwd_grant has=%b rd_en=%b want 1 0001", fwd_has_buf, buf_rd_en);
    end
    fwd_rd_en = 0; fwd_done = 1; tick(); fwd_done = 0;
    for (int k = 0; k < 3; k++) begin
      sn_done = 1; tick(); sn_done = 0; tick();
      w = '0; w[order[k]] = 1'b1;
      sn_wr_en = 1; #1;
      checks++;
      if (buf_wr_en !== w) begin
        errors++; $display("FAIL sn_order step %0d got=%b want %b", k, buf_wr_en, w);
      end
      sn_wr_en = 0;
    end
  endtask

  task automatic test_same_cycle();
    int order[3] = '{3, 0, 1};
    logic [NB-1:0] w;
    do_reset();
    sn_done = 1; tick(); sn_done = 0; tick();
    cpu_accept = 1; tick(); cpu_accept = 0; tick();
    sn_done = 1; tick(); sn_done = 0; tick();
    checks++;
    if ({sn_has_buf, cpu_has_buf, fwd_has_buf} !== 3'b111) begin
      errors++; $display("FAIL same_setup has=%b%b%b want 111", sn_has_buf, cpu_has_buf,
        fwd_has_buf);
    end
    cpu_reject = 1; fwd_done = 1; tick(); cpu_reject = 0; fwd_done = 0;
    for (int k = 0; k < 3; k++) begin
      sn_done = 1; tick(); sn_done = 0; tick();
      w = '0; w[order[k]] = 1'b1;
      sn_wr_en = 1; #1;
      checks++;
      if (buf_wr_en !== w) begin
        errors++; $display("FAIL free_order step %0d got=%b want %b", k, buf_wr_en, w);
      end
      sn_wr_en = 0;
    end
    // CPU holds buffer 2 here: accept and reject together must drop it.
    cpu_accept = 1; cpu_reject = 1; tick(); cpu_accept = 0; cpu_reject = 0;
    tick(); tick();
    checks++;
    if (fwd_has_buf !== 1'b0) begin
      errors++; $display("FAIL acc_rej_fwd got=%b want 0", fwd_has_buf);
    end
    sn_done = 1; tick(); sn_done = 0; tick();
    sn_wr_en = 1; #1;
    checks++;
    if (buf_wr_en !== 4'b0100) begin
      errors++; $display("FAIL acc_rej_freed got=%b want 0100", buf_wr_en);
    end
    sn_wr_en = 0;
  endtask

  task automatic test_starve();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sn_done = 1; tick(); sn_done = 0; tick();
    end
    tick(); tick();
    sn_wr_en = 1; #1;
    checks++;
    if (sn_has_buf !== 1'b0 || cpu_has_buf !== 1'b1 || buf_wr_en !== 4'b0000) begin
      errors++; $display("FAIL starve sn=%b cpu=%b wr_en=%b want 0 1 0000", sn_has_buf,
        cpu_has_buf, buf_wr_en);
    end
    sn_wr_en = 0;
    cpu_reject = 1; tick(); cpu_reject = 0;
    checks++;
    if (sn_has_buf !== 1'b0) begin
      errors++; $display("FAIL starve_gap got=%b want 0", sn_has_buf);
    end
    tick();
    sn_wr_en = 1; #1;
    checks++;
    if (sn_has_buf !== 1'b1 || buf_wr_en !== 4'b0001) begin
      errors++; $display("FAIL starve_regrant has=%b wr_en=%b want 1 0001", sn_has_buf,
        buf_wr_en);
    end
    sn_wr_en = 0;
  endtask

  task automatic test_random();
    logic [DW-1:0] e_cpu_rd, e_fwd_rd;
    logic [AW-1:0] e_cpu_len, e_fwd_len;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sn_addr    = AW'($urandom_range(0, 63));
      sn_wr_data = {$urandom, $urandom};
      sn_wr_en   = 1'($urandom_range(0, 1));
      sn_done    = ($urandom_range(0, 3) == 0);
      cpu_addr   = AW'($urandom_range(0, 63));
      cpu_rd_en  = 1'($urandom_range(0, 1));
      cpu_accept = ($urandom_range(0, 3) == 0);
      cpu_reject = ($urandom_range(0, 5) == 0);
      fwd_addr   = AW'($urandom_range(0, 63));
      fwd_rd_en  = 1'($urandom_range(0, 1));
      fwd_done   = ($urandom_range(0, 2) == 0);
      #1;
      e_cpu_rd  = m_cpu_has ? mem[m_cpu_idx][cpu_addr[5:0]] : '0;
      e_fwd_rd  = m_fwd_has ? mem[m_fwd_idx][fwd_addr[5:0]] : '0;
      e_cpu_len = m_cpu_has ? buf_len[m_cpu_idx*AW +: AW] : '0;
      e_fwd_len = m_fwd_has ? buf_len[m_fwd_idx*AW +: AW] : '0;
      checks++;
      if ({sn_has_buf, cpu_has_buf, fwd_has_buf} !== {m_sn_has, m_cpu_has, m_fwd_has}) begin
        errors++; $display("FAIL rnd_has cyc %0d got=%b%b%b want %b%b%b", c, sn_has_buf,
          cpu_has_buf, fwd_has_buf, m_sn_has, m_cpu_has, m_fwd_has);
      end
      checks++;
      if (buf_wr_en !== exp_wr_en() || buf_rd_en !== exp_rd_en()) begin
        errors++; $display("FAIL rnd_en cyc %0d wr=%b rd=%b want %b %b", c, buf_wr_en,
          buf_rd_en, exp_wr_en(), exp_rd_en());
      end
      checks++;
      if (buf_addr !== exp_addr() || buf_wr_data !== exp_wdata()) begin
        errors++; $display("FAIL rnd_route cyc %0d addr=%h want %h", c, buf_addr, exp_addr());
      end
      checks++;
      if ({cpu_rd_data, fwd_rd_data, cpu_len, fwd_len} !==
          {e_cpu_rd, e_fwd_rd, e_cpu_len, e_fwd_len}) begin
        errors++; $display("FAIL rnd_read cyc %0d cpu=%h/%0d fwd=%h/%0d want %h/%0d %h/%0d", c,
          cpu_rd_data, cpu_len, fwd_rd_data, fwd_len, e_cpu_rd, e_cpu_len, e_fwd_rd, e_fwd_len);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reg_out();
    g_rst = 1; g_sn_wr_en = 0; g_sn_addr = '0; g_sn_wr_data = '0;
    tick(); tick();
    checks++;
    if (g_buf_wr_en !== '0 || g_buf_addr !== '0 || g_sn_has !== 1'b0) begin
      errors++; $display("FAIL reg_reset wr_en=%b has=%b want 000 0", g_buf_wr_en, g_sn_has);
    end
    g_rst = 0; tick();
    g_sn_wr_en = 1; g_sn_addr = 10'd9; g_sn_wr_data = 64'h1234; #1;
    checks++;
    if (g_sn_has !== 1'b1 || g_buf_wr_en !== 3'b000) begin
      errors++; $display("FAIL reg_lag_rise has=%b wr_en=%b want 1 000", g_sn_has, g_buf_wr_en);
    end
    tick();
    checks++;
    if (g_buf_wr_en !== 3'b001 || g_buf_addr[AW-1:0] !== 10'd9 ||
        g_buf_wr_data[DW-1:0] !== 64'h1234) begin
      errors++; $display("FAIL reg_out wr_en=%b addr=%0d data=%h want 001 9 1234", g_buf_wr_en,
        g_buf_addr[AW-1:0], g_buf_wr_data[DW-1:0]);
    end
    checks++;
    if ({g_cpu_has, g_fwd_has, g_buf_rd_en, g_cpu_rd_data, g_fwd_rd_data, g_cpu_len,
         g_fwd_len} !== '0) begin
      errors++; $display("FAIL reg_unowned cpu=%b fwd=%b rd_en=%b want zeros", g_cpu_has,
        g_fwd_has, g_buf_rd_en);
    end
    g_sn_wr_en = 0; #1;
    checks++;
    if (g_buf_wr_en !== 3'b001) begin
      errors++; $display("FAIL reg_lag_fall got=%b want 001", g_buf_wr_en);
    end
    tick();
    checks++;
    if (g_buf_wr_en !== 3'b000) begin
      errors++; $display("FAIL reg_fall got=%b want 000", g_buf_wr_en);
    end
    g_sn_wr_en = 1; tick();
    g_rst = 1; tick();
    checks++;
    if (g_buf_wr_en !== 3'b000 || g_sn_has !== 1'b0) begin
      errors++; $display("FAIL reg_mid_reset wr_en=%b has=%b want 000 0", g_buf_wr_en,
        g_sn_has);
    end
    g_sn_wr_en = 0; g_rst = 0; tick();
  endtask

  initial begin
    for (int i = 0; i < NB; i++) buf_len[i*AW +: AW] = AW'($urandom_range(1, 1023));
    g_rst = 1; g_sn_wr_en = 0; g_sn_addr = '0; g_sn_wr_data = '0;
    test_reset();
    test_handoff();
    test_rotation();
    test_same_cycle();
    test_starve();
    test_random();
    test_reg_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
